// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, instruction classes and encodings for the multicycle controller
package riscv_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [1:0] {CL_R, CL_I, CL_LOAD, CL_STORE} iclass_t;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;
    localparam logic [1:0] TC_NONE     = 2'b00;
    localparam logic [1:0] TC_ILLEGAL  = 2'b01;
    localparam logic [1:0] TC_FETCH_TO = 2'b10;
    localparam logic [1:0] TC_DATA_TO  = 2'b11;
    function automatic logic [1:0] alu_op_of(iclass_t c);
        return c == CL_R ? ALU_R : c == CL_I ? ALU_I : ALU_ADD;
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller to datapath/memory strobe bundle
interface multicycle_controller_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        inst_req;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem2reg;
    logic [1:0]  alu_op;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    modport master (
        input  opcode, mem_ready,
        output inst_req, ir_write, pc_write, reg_write, alu_src, mem_read, mem_write,
               mem2reg, alu_op, trap, trap_cause, instret
    );
    modport slave (
        output opcode, mem_ready,
        input  inst_req, ir_write, pc_write, reg_write, alu_src, mem_read, mem_write,
               mem2reg, alu_op, trap, trap_cause, instret
    );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: wait-cycle counter shared by FETCH and MEM; expired marks the last allowed cycle
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        cnt <= (reset || clr) ? '0 : en ? cnt + 8'd1 : cnt;
    // expired in the TIMEOUT_CYCLES-th waiting cycle; a ready in that same cycle still wins
    assign expired = cnt == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with ready handshake, timeout and illegal-opcode trap
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    state_t      state, state_n;
    iclass_t     cls, cls_n;
    logic [1:0]  cause, cause_n;
    logic [31:0] instret;
    logic        waiting, expired, retire, run, in_alu;
    assign waiting = state == FETCH || state == MEM;
    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!waiting || bus.mem_ready),
        .en      (waiting),
        .expired (expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            cls     <= CL_R;
            cause   <= TC_NONE;
            instret <= '0;
        end else begin
            state   <= state_n;
            cls     <= cls_n;
            cause   <= cause_n;
            instret <= instret + 32'(retire);
        end
    end
    always_comb begin
        state_n = state;
        cls_n   = cls;
        cause_n = cause;
        retire  = 1'b0;
        case (state)
            FETCH: begin
                state_n = bus.mem_ready ? DECODE : expired ? TRAP : FETCH;
                cause_n = (!bus.mem_ready && expired) ? TC_FETCH_TO : cause;
            end
            DECODE: begin
                state_n = EXEC;
                case (bus.opcode)
                    OP_R:     cls_n = CL_R;
                    OP_I:     cls_n = CL_I;
                    OP_LOAD:  cls_n = CL_LOAD;
                    OP_STORE: cls_n = CL_STORE;
                    default: begin
                        state_n = TRAP;
                        cause_n = TC_ILLEGAL;
                    end
                endcase
            end
            EXEC: state_n = (cls == CL_LOAD || cls == CL_STORE) ? MEM : WB;
            MEM: begin
                state_n = bus.mem_ready ? (cls == CL_LOAD ? WB : FETCH) : expired ? TRAP : MEM;
                cause_n = (!bus.mem_ready && expired) ? TC_DATA_TO : cause;
                retire  = bus.mem_ready && cls == CL_STORE;
            end
            WB: begin
                state_n = FETCH;
                retire  = 1'b1;
            end
            default: state_n = TRAP;
        endcase
    end
    // every strobe is forced low while reset is held, whatever the state register says
    assign run            = !reset;
    assign in_alu         = state == EXEC || state == MEM || state == WB;
    assign bus.inst_req   = run && state == FETCH;
    assign bus.ir_write   = run && state == FETCH && bus.mem_ready;
    assign bus.pc_write   = run && (state == WB || (state == MEM && cls == CL_STORE && bus.mem_ready));
    assign bus.reg_write  = run && state == WB;
    assign bus.alu_src    = run && in_alu && cls != CL_R;
    assign bus.alu_op     = (run && in_alu) ? alu_op_of(cls) : ALU_ADD;
    assign bus.mem_read   = run && state == MEM && cls == CL_LOAD;
    assign bus.mem_write  = run && state == MEM && cls == CL_STORE;
    assign bus.mem2reg    = run && state == WB && cls == CL_LOAD;
    assign bus.trap       = run && state == TRAP;
    assign bus.trap_cause = run ? cause : TC_NONE;
    assign bus.instret    = instret;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle vector table through a scoreboard queue, plus a back-to-back ADDI run
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    multicycle_controller_if bus();
    multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [12:0] sig;
        logic [31:0] ins;
    } vec_t;
    vec_t tbl[$];
    vec_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011, S = 7'b0100011, J = 7'b1101111;
    // inst_req ir_write pc_write reg_write alu_src mem_read mem_write mem2reg alu_op trap cause
    localparam logic [12:0] Z     = 13'b0_0_0_0_0_0_0_0_00_0_00;
    localparam logic [12:0] F_W   = 13'b1_0_0_0_0_0_0_0_00_0_00;
    localparam logic [12:0] F_A   = 13'b1_1_0_0_0_0_0_0_00_0_00;
    localparam logic [12:0] EX_R  = 13'b0_0_0_0_0_0_0_0_10_0_00;
    localparam logic [12:0] EX_I  = 13'b0_0_0_0_1_0_0_0_11_0_00;
    localparam logic [12:0] EX_M  = 13'b0_0_0_0_1_0_0_0_00_0_00;
    localparam logic [12:0] M_LD  = 13'b0_0_0_0_1_1_0_0_00_0_00;
    localparam logic [12:0] M_ST  = 13'b0_0_0_0_1_0_1_0_00_0_00;
    localparam logic [12:0] M_STA = 13'b0_0_1_0_1_0_1_0_00_0_00;
    localparam logic [12:0] WB_R  = 13'b0_0_1_1_0_0_0_0_10_0_00;
    localparam logic [12:0] WB_I  = 13'b0_0_1_1_1_0_0_0_11_0_00;
    localparam logic [12:0] WB_L  = 13'b0_0_1_1_1_0_0_1_00_0_00;
    localparam logic [12:0] T_IL  = 13'b0_0_0_0_0_0_0_0_00_1_01;
    localparam logic [12:0] T_FT  = 13'b0_0_0_0_0_0_0_0_00_1_10;
    localparam logic [12:0] T_DT  = 13'b0_0_0_0_0_0_0_0_00_1_11;
    logic [12:0] sig;
    assign sig = {bus.inst_req, bus.ir_write, bus.pc_write, bus.reg_write, bus.alu_src,
                  bus.mem_read, bus.mem_write, bus.mem2reg, bus.alu_op, bus.trap, bus.trap_cause};
    task automatic add(input logic r, input logic [6:0] op, input logic rdy, input logic [12:0] s, input logic [31:0] n);
        tbl.push_back({r, op, rdy, s, n});
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial begin
        vec_t v;
        int pcw, third;
        bus.opcode = R;
        bus.mem_ready = 1'b0;
        add(1, R, 0, Z, 0);
        // R-type with zero-wait memory; ready in DECODE/EXEC/WB is ignored
        add(0, R, 1, F_A, 0); add(0, R, 1, Z, 0); add(0, R, 1, EX_R, 0); add(0, R, 1, WB_R, 0);
        // LW with three wait cycles in MEM
        add(0, L, 1, F_A, 1); add(0, L, 0, Z, 1); add(0, L, 0, EX_M, 1);
        for (int k = 0; k < 3; k++) add(0, L, 0, M_LD, 1);
        add(0, L, 1, M_LD, 1); add(0, L, 0, WB_L, 1);
        // SW acked in first MEM cycle, then straight back to FETCH with an ADDI
        add(0, S, 1, F_A, 2); add(0, S, 0, Z, 2); add(0, S, 0, EX_M, 2); add(0, S, 1, M_STA, 2);
        add(0, I, 1, F_A, 3); add(0, I, 0, Z, 3); add(0, I, 0, EX_I, 3); add(0, I, 0, WB_I, 3);
        // ready on the 16th FETCH cycle is success; then JAL traps illegal, late ready ignored
        for (int k = 0; k < 15; k++) add(0, J, 0, F_W, 4);
        add(0, J, 1, F_A, 4); add(0, J, 0, Z, 4); add(0, J, 1, T_IL, 4); add(0, J, 1, T_IL, 4);
        add(1, R, 0, Z, 4);
        for (int k = 0; k < 16; k++) add(0, R, 0, F_W, 0);
        add(0, R, 1, T_FT, 0); add(0, R, 1, T_FT, 0);
        add(1, L, 0, Z, 0);
        add(0, L, 1, F_A, 0); add(0, L, 0, Z, 0); add(0, L, 0, EX_M, 0);
        for (int k = 0; k < 16; k++) add(0, L, 0, M_LD, 0);
        add(0, L, 1, T_DT, 0);
        add(1, I, 0, Z, 0);
        add(0, I, 1, F_A, 0); add(0, I, 1, Z, 0); add(0, I, 1, EX_I, 0); add(0, I, 1, WB_I, 0);
        // reset while a store is pending in MEM
        add(0, S, 1, F_A, 1); add(0, S, 0, Z, 1); add(0, S, 0, EX_M, 1); add(0, S, 0, M_ST, 1);
        add(1, S, 1, Z, 1);
        add(0, I, 0, F_W, 0);
        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            #1;
            reset = tbl[i].rst;
            bus.opcode = tbl[i].op;
            bus.mem_ready = tbl[i].rdy;
            sb.push_back(tbl[i]);
            @(negedge clk);
            v = sb.pop_front();
            check($sformatf("row%0d strobes", i), 32'(sig), 32'(v.sig));
            check($sformatf("row%0d instret", i), bus.instret, v.ins);
            @(posedge clk);
        end
        // three back-to-back ADDIs with memory always ready: third retire in cycle 12
        #1;
        bus.opcode = I;
        bus.mem_ready = 1'b1;
        pcw = 0;
        third = 0;
        for (int c = 1; c <= 40 && third == 0; c++) begin
            @(negedge clk);
            if (bus.pc_write) pcw++;
            if (pcw == 3) third = c;
        end
        check("addi third retire cycle", 32'(third), 32'd12);
        @(negedge clk);
        check("addi instret", bus.instret, 32'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
